// File: rtl/jtpopeye_dma_bus.sv
// Object RAM owner and bus-request responder between the object DMA, the CPU core and the CPU decoder.
// Define JTPOPEYE_DMA_WATCHDOG_EN to force release when the CPU never acknowledges within WDOG_MAX cpu_cen ticks.
module jtpopeye_dma_bus #(
  parameter int WDOG_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       busrq_n,
  output logic       busak_n,
  output logic       cpu_busrq_n,
  input  logic       cpu_busak_n,
  input  logic       cpu_cs,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  input  logic       dma_cs,
  input  logic [9:0] AD_DMA,
  output logic [7:0] DD_DMA,
  output logic [9:0] dma_cnt,
  output logic       wdog_err
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, REL} state_t;

  state_t     state_q, state_d;
  logic       busak_n_q, busak_n_d;
  logic       cpu_busrq_n_q, cpu_busrq_n_d;
  logic [7:0] dd_dma_q, dd_dma_d;
  logic [7:0] cpu_din_q, cpu_din_d;
  logic [9:0] dma_cnt_q, dma_cnt_d;
  logic       wdog_hit;
  logic [7:0] mem [0:1023];

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
  localparam int WW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_err_q, wdog_err_d;

  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == REQ)
      wdog_cnt_d = cpu_cen ? wdog_cnt_q + WW'(1) : wdog_cnt_q;
    wdog_hit   = (state_q == REQ) && cpu_busak_n && (wdog_cnt_q == WW'(WDOG_MAX));
    wdog_err_d = wdog_err_q | wdog_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^32'(WDOG_MAX);
  assign wdog_hit    = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  // Handshake outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!busrq_n) state_d = REQ;
      REQ: begin
        if (!cpu_busak_n)            state_d = GRANT;
        else if (busrq_n || wdog_hit) state_d = REL;
      end
      GRANT:   if (busrq_n) state_d = REL;
      REL:     if (cpu_busak_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busak_n_d     = (state_d != GRANT);
    cpu_busrq_n_d = !((state_d == REQ) || (state_d == GRANT));
  end

  // busak_n_q steers the RAM port, so a CPU write on the grant-entry edge still lands.
  always_comb begin
    dd_dma_d  = dd_dma_q;
    dma_cnt_d = dma_cnt_q;
    if (state_q == GRANT && dma_cs) begin
      dd_dma_d  = mem[AD_DMA];
      dma_cnt_d = dma_cnt_q + 10'd1;
    end
    if (state_q != GRANT && state_d == GRANT)
      dma_cnt_d = 10'd0;
    cpu_din_d = busak_n_q ? mem[cpu_addr] : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busak_n_q     <= 1'b1;
      cpu_busrq_n_q <= 1'b1;
      dd_dma_q      <= 8'h00;
      cpu_din_q     <= 8'h00;
      dma_cnt_q     <= 10'd0;
    end else begin
      state_q       <= state_d;
      busak_n_q     <= busak_n_d;
      cpu_busrq_n_q <= cpu_busrq_n_d;
      dd_dma_q      <= dd_dma_d;
      cpu_din_q     <= cpu_din_d;
      dma_cnt_q     <= dma_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (busak_n_q && cpu_cs && cpu_we && cpu_cen)
      mem[cpu_addr] <= cpu_dout;
  end

  assign busak_n     = busak_n_q;
  assign cpu_busrq_n = cpu_busrq_n_q;
  assign DD_DMA      = dd_dma_q;
  assign cpu_din     = cpu_din_q;
  assign dma_cnt     = dma_cnt_q;

endmodule
